// File: rtl/pal_macrocell_array.sv
// rtl/pal_macrocell_array.sv - PAL fabric: shared-term AND array, OR array, macrocells, serial config
//
// Purpose:
//   Programmable AND array of T shared product terms over NI variables, a programmable
//   OR array onto M outputs, and one macrocell per output (combinational or registered,
//   optional inversion). Configuration is shifted serially into a shadow chain, its bit
//   count is checked, and only a correct-length load is copied into the live config,
//   so the running function never sees a partial load.
//
// Optional feature macro: PAL_FEEDBACK_EN
//   Defined:   NI = N+M. AND-array variables N..N+M-1 are the macrocell outputs.
//   Undefined: NI = N. No feedback path.
//
// Ports:
//   CLK          in   1   config shift clock and macrocell register clock
//   RES_N        in   1   asynchronous active-low reset
//   EN           in   1   config shift enable
//   CFG          in   1   serial config bit
//   INPUT_VARS   in   N   logic inputs
//   OUTPUT_VALS  out  M   macrocell outputs
//   CFG_DONE     out  1   last load committed
//   CFG_ERR      out  1   last load had the wrong bit count and was discarded
//
// Config layout (LSB first; first bit shifted ends at CFG_LEN-1):
//   [2M-1:0]              macrocell k: bit 2k = REG_k, bit 2k+1 = INV_k
//   next M*T bits         OR array: bit k*T+t connects term t to output k
//   top T*2*NI bits       AND array: term t, var i: bit 2i = true, bit 2i+1 = complement

module pal_macrocell_array #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int T = 8
) (
  input  logic         CLK,
  input  logic         RES_N,
  input  logic         EN,
  input  logic         CFG,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS,
  output logic         CFG_DONE,
  output logic         CFG_ERR
);

`ifdef PAL_FEEDBACK_EN
  localparam int NI = N + M;
`else
  localparam int NI = N;
`endif

  localparam int CFG_LEN  = T*2*NI + M*T + 2*M;
  localparam int OR_BASE  = 2*M;
  localparam int AND_BASE = 2*M + M*T;
  localparam int CW       = $clog2(CFG_LEN + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_LEN);
  // One past full length: enough to tell "too long" apart without the counter wrapping.
  localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [CFG_LEN-1:0]  r_shadow;
  logic [CFG_LEN-1:0]  r_active;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic                r_err;
  logic [M-1:0]        r_flop;

  logic [CFG_LEN-1:0]  w_shift;
  logic [NI-1:0]       w_vars;
  logic [T-1:0][NI-1:0] w_lit_ok;
  logic [T-1:0][NI-1:0] w_lit_con;
  logic [T-1:0]        w_term;
  logic [M-1:0]        w_v;
  logic [M-1:0]        w_out;

  assign w_shift = {r_shadow[CFG_LEN-2:0], CFG};

  // ---------------------------------------------------------------------------
  // Configuration FSM. Shadow and counter only move while loading; the live
  // config changes in exactly one place, the COMMIT cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (EN) begin
            // The entry edge already samples the first bit, so the count starts at 1.
            r_state  <= S_SHIFT;
            r_shadow <= w_shift;
            r_cnt    <= CW'(1);
            r_done   <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (EN) begin
            r_shadow <= w_shift;
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_cnt == CNT_FULL) begin
            r_state <= S_COMMIT;
          end else begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end
        end
        S_COMMIT: begin
          // EN is deliberately not looked at here; a new load starts from IDLE.
          r_active <= r_shadow;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // AND array variables
  // ---------------------------------------------------------------------------
`ifdef PAL_FEEDBACK_EN
  // Feedback is taken after the REG mux; a combinational macrocell fed back
  // into its own cone is a user configuration error and is not guarded.
  assign w_vars = {w_out, INPUT_VARS};
`else
  assign w_vars = INPUT_VARS;
`endif

  // ---------------------------------------------------------------------------
  // AND array: a literal that is not connected is neutral (ok=1). A term with
  // no connected literal is forced to 0, and x & ~x falls out naturally as 0.
  // ---------------------------------------------------------------------------
  for (genvar gt = 0; gt < T; gt++) begin : g_term
    for (genvar gi = 0; gi < NI; gi++) begin : g_lit
      localparam int BT = AND_BASE + gt*2*NI + 2*gi;
      assign w_lit_ok[gt][gi]  = (~r_active[BT] |  w_vars[gi]) &
                                 (~r_active[BT+1] | ~w_vars[gi]);
      assign w_lit_con[gt][gi] = r_active[BT] | r_active[BT+1];
    end
    assign w_term[gt] = (|w_lit_con[gt]) & (&w_lit_ok[gt]);
  end

  // ---------------------------------------------------------------------------
  // OR array and macrocells
  // ---------------------------------------------------------------------------
  for (genvar gk = 0; gk < M; gk++) begin : g_mc
    assign w_v[gk]   = (|(w_term & r_active[OR_BASE + gk*T +: T])) ^ r_active[2*gk+1];
    assign w_out[gk] = r_active[2*gk] ? r_flop[gk] : w_v[gk];
  end

  // Macrocell flops run every cycle regardless of the config FSM state.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      r_flop <= '0;
    end else begin
      r_flop <= w_v;
    end
  end

  assign OUTPUT_VALS = w_out;
  assign CFG_DONE    = r_done;
  assign CFG_ERR     = r_err;

endmodule
